// File: rtl/proc_seq_ctrl_if.sv
// proc_seq_ctrl_if: memory request/acknowledge handshake between the sequencer and the memory model.
interface proc_seq_ctrl_if;
    logic MEM_REQ;
    logic MEM_WE;
    logic MEM_ACK;
    modport master (output MEM_REQ, output MEM_WE, input MEM_ACK);
    modport slave (input MEM_REQ, input MEM_WE, output MEM_ACK);
endinterface

// File: rtl/proc_seq_ctrl.sv
// proc_seq_ctrl: multi-cycle fetch/decode/execute/memory/write-back sequencer that owns the PC.
// Define PROC_SEQ_PERF_EN to build the cycle and retired-instruction counters.
module proc_seq_ctrl #(
    parameter int PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                CLK,
    input  logic                RST,
    proc_seq_ctrl_if.master     bus,
    input  logic                MEM_OP,
    input  logic                MEM_OP_WE,
    input  logic                STALL,
    input  logic                WB_WRITE,
    input  logic                PC_LOAD,
    input  logic [PC_WIDTH-1:0] PC_TARGET,
    input  logic                HALT_REQ,
    input  logic                RESUME,
    output logic [2:0]          STATE,
    output logic [PC_WIDTH-1:0] PC,
    output logic                IR_LOAD,
    output logic                RF_WRITE,
    output logic                RETIRE,
    output logic                TIMEOUT,
    output logic [31:0]         CYCLE_CNT,
    output logic [31:0]         INSTR_CNT
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXE    = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [2:0]          state, state_nxt;
    logic [PC_WIDTH-1:0] pc;
    logic [WW-1:0]       wait_cnt;
    logic                op_we;
    logic                mem_st;
    logic                expired;

    assign mem_st  = state == S_FETCH || state == S_MEM;
    // An ACK arriving on the last allowed cycle takes priority over the timeout.
    assign expired = mem_st && !bus.MEM_ACK && wait_cnt == WAIT_LAST;

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = bus.MEM_ACK ? S_DECODE : expired ? S_ERR : S_FETCH;
            S_DECODE: state_nxt = S_EXE;
            S_EXE:    state_nxt = STALL ? S_EXE : MEM_OP ? S_MEM : S_WB;
            S_MEM:    state_nxt = bus.MEM_ACK ? S_WB : expired ? S_ERR : S_MEM;
            S_WB:     state_nxt = HALT_REQ ? S_HALT : S_FETCH;
            S_HALT:   state_nxt = RESUME ? S_FETCH : S_HALT;
            default:  state_nxt = S_ERR;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            wait_cnt <= '0;
            op_we    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state_nxt != state || !mem_st) ? '0 : wait_cnt + 1'b1;
            if (state == S_EXE && !STALL)
                op_we <= MEM_OP_WE;
            if (state == S_WB)
                pc <= PC_LOAD ? PC_TARGET : pc + 1'b1;
        end
    end

    assign STATE       = state;
    assign PC          = pc;
    assign bus.MEM_REQ = mem_st && !RST;
    assign bus.MEM_WE  = state == S_MEM && op_we;
    assign IR_LOAD     = state == S_DECODE;
    assign RF_WRITE    = state == S_WB && WB_WRITE;
    assign RETIRE      = state == S_WB;
    assign TIMEOUT     = state == S_ERR;

`ifdef PROC_SEQ_PERF_EN
    logic [31:0] cyc_cnt, ins_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else begin
            if (state != S_HALT && state != S_ERR)
                cyc_cnt <= cyc_cnt + 1'b1;
            if (state == S_WB)
                ins_cnt <= ins_cnt + 1'b1;
        end
    end

    assign CYCLE_CNT = cyc_cnt;
    assign INSTR_CNT = ins_cnt;
`else
    assign CYCLE_CNT = '0;
    assign INSTR_CNT = '0;
`endif
endmodule

// File: tb/tb_proc_seq_ctrl.sv
// tb_proc_seq_ctrl: randomized instruction plans expanded into per-cycle expectations and replayed on the sequencer.
module tb_proc_seq_ctrl;
    localparam int TO = 4;
`ifdef PROC_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        MEM_OP = 1'b0, MEM_OP_WE = 1'b0, STALL = 1'b0, WB_WRITE = 1'b0;
    logic        PC_LOAD = 1'b0, HALT_REQ = 1'b0, RESUME = 1'b0;
    logic [3:0]  PC_TARGET = '0;
    logic [2:0]  STATE;
    logic [3:0]  PC;
    logic        IR_LOAD, RF_WRITE, RETIRE, TIMEOUT;
    logic [31:0] CYCLE_CNT, INSTR_CNT;

    proc_seq_ctrl_if bus();

    proc_seq_ctrl #(.PC_WIDTH(4), .RESET_PC(4'd0), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .bus(bus),
        .MEM_OP(MEM_OP), .MEM_OP_WE(MEM_OP_WE), .STALL(STALL), .WB_WRITE(WB_WRITE),
        .PC_LOAD(PC_LOAD), .PC_TARGET(PC_TARGET), .HALT_REQ(HALT_REQ), .RESUME(RESUME),
        .STATE(STATE), .PC(PC), .IR_LOAD(IR_LOAD), .RF_WRITE(RF_WRITE), .RETIRE(RETIRE),
        .TIMEOUT(TIMEOUT), .CYCLE_CNT(CYCLE_CNT), .INSTR_CNT(INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ack, op, we, stall, wbw, pcl, hreq, res;
        logic [3:0] tgt;
        logic [2:0] st;
        logic [3:0] pc;
        logic       req, mwe, ir, rf, ret, tmo;
    } cyc_t;

    cyc_t       q[$];
    logic [3:0] pc_m = '0;
    int         cyc_m = 0, ins_m = 0;
    int         n_chk = 0, n_ok = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One cycle in a given state with every input not meaningful there randomized.
    function automatic cyc_t mk(input logic [2:0] st);
        cyc_t c;
        c.ack = 1'($urandom); c.op = 1'($urandom); c.we = 1'($urandom);
        c.stall = 1'($urandom); c.wbw = 1'($urandom); c.pcl = ($urandom_range(3) == 0);
        c.hreq = 1'($urandom); c.res = 1'($urandom); c.tgt = 4'($urandom);
        c.st = st; c.pc = pc_m;
        c.req = st == 3'd0 || st == 3'd3; c.mwe = 1'b0; c.ir = st == 3'd1;
        c.rf = 1'b0; c.ret = st == 3'd4; c.tmo = st == 3'd6;
        return c;
    endfunction

    task automatic plan_instr(input int f, input bit plain, input int tgt);
        cyc_t c;
        int s, d, g;
        bit m, w, h;
        s = (!plain && $urandom_range(3) == 0) ? $urandom_range(5, 1) : 0;
        m = !plain && 1'($urandom);
        w = 1'($urandom);
        d = $urandom_range(3);
        h = !plain && $urandom_range(5) == 0;
        for (int i = 0; i <= f; i++) begin c = mk(3'd0); c.ack = (i == f); q.push_back(c); end
        q.push_back(mk(3'd1));
        for (int i = 0; i <= s; i++) begin
            c = mk(3'd2); c.stall = (i < s);
            if (i == s) begin c.op = m; c.we = w; end
            q.push_back(c);
        end
        if (m) for (int i = 0; i <= d; i++) begin c = mk(3'd3); c.ack = (i == d); c.mwe = w; q.push_back(c); end
        c = mk(3'd4); c.hreq = h; c.rf = c.wbw;
        if (plain) c.pcl = 1'b0;
        if (tgt >= 0) begin c.pcl = 1'b1; c.tgt = 4'(tgt); end
        q.push_back(c);
        pc_m = c.pcl ? c.tgt : pc_m + 4'd1;
        if (h) begin
            g = $urandom_range(10, 1);
            for (int i = 0; i < g; i++) begin c = mk(3'd5); c.res = (i == g - 1); q.push_back(c); end
        end
    endtask

    task automatic plan_timeout();
        cyc_t c;
        for (int i = 0; i < TO; i++) begin c = mk(3'd0); c.ack = 1'b0; q.push_back(c); end
        for (int i = 0; i < 5; i++) q.push_back(mk(3'd6));
    endtask

    task automatic play(input int n);
        cyc_t c;
        for (int k = 0; k < n && q.size() > 0; k++) begin
            c = q.pop_front();
            bus.MEM_ACK = c.ack; MEM_OP = c.op; MEM_OP_WE = c.we; STALL = c.stall;
            WB_WRITE = c.wbw; PC_LOAD = c.pcl; PC_TARGET = c.tgt; HALT_REQ = c.hreq; RESUME = c.res;
            #1;
            check("state", 32'(STATE), 32'(c.st));
            check("pc", 32'(PC), 32'(c.pc));
            check("strobes", 32'({bus.MEM_REQ, bus.MEM_WE, IR_LOAD, RF_WRITE, RETIRE, TIMEOUT}),
                  32'({c.req, c.mwe, c.ir, c.rf, c.ret, c.tmo}));
            check("cycle_cnt", CYCLE_CNT, PERF ? 32'(cyc_m) : 32'd0);
            check("instr_cnt", INSTR_CNT, PERF ? 32'(ins_m) : 32'd0);
            if (c.st != 3'd5 && c.st != 3'd6) cyc_m++;
            if (c.st == 3'd4) ins_m++;
            @(negedge CLK);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.MEM_ACK = 1'b1;
        #1;
        check("rst_state", 32'(STATE), 32'd0);
        check("rst_pc", 32'(PC), 32'd0);
        check("rst_strobes", 32'({bus.MEM_REQ, bus.MEM_WE, IR_LOAD, RF_WRITE, RETIRE, TIMEOUT}), 32'd0);
        check("rst_cnt", CYCLE_CNT | INSTR_CNT, 32'd0);
        pc_m = '0; cyc_m = 0; ins_m = 0;
        q.delete();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        bus.MEM_ACK = 1'b0;
        @(negedge CLK);
        do_reset();
        for (int i = 0; i < 3; i++) begin plan_instr(0, 1'b1, -1); play(q.size()); end
        plan_instr(0, 1'b1, 15); play(q.size());
        plan_instr(0, 1'b1, -1); play(q.size());
        plan_instr(0, 1'b1, 9); play(q.size());
        for (int i = 0; i < 60; i++) begin plan_instr($urandom_range(3), 1'b0, -1); play(q.size()); end
        plan_timeout(); play(q.size());
        do_reset();
        plan_instr(TO - 1, 1'b0, -1); play(q.size());
        for (int i = 0; i < 3; i++) begin
            plan_instr($urandom_range(3), 1'b0, -1);
            play($urandom_range(q.size() - 1, 1));
            do_reset();
        end
        for (int i = 0; i < 20; i++) begin plan_instr($urandom_range(3), 1'b0, -1); play(q.size()); end
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
